// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN streaming datapath.
//  - PIX_W      : default pixel width
//  - WIN_TAPS   : number of taps in a 3x3 window
//  - TAP_*      : tap index inside a packed window; row-major, oldest row and
//                 oldest column at index 0, newest pixel at index 8
//  - stride_t   : window stride encoding
//  - lb_state_t : line-buffer frame state
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = 9;

    // Top row (oldest line)
    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    // Middle row
    localparam int TAP_ML = 3;
    localparam int TAP_MC = 4;
    localparam int TAP_MR = 5;
    // Bottom row (current line, TAP_BR is the newest pixel)
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;

    typedef enum logic {
        STRIDE_1 = 1'b0,
        STRIDE_2 = 1'b1
    } stride_t;

    typedef enum logic {
        LB_IDLE = 1'b0,
        LB_RUN  = 1'b1
    } lb_state_t;

endpackage

// File: rtl/com_line_ram.sv
// -----------------------------------------------------------------------------
// com_line_ram
// Single-port line memory: synchronous write, asynchronous read at the same
// address, so the old word can be read and replaced in one cycle.
// Ports:
//  clk    in  1       write clock, rising edge
//  we     in  1       write enable
//  addr   in  ADDR_W  read/write address (must be < DEPTH)
//  wdata  in  WIDTH   write data
//  rdata  out WIDTH   contents at addr before this cycle's write
// -----------------------------------------------------------------------------
module com_line_ram #(
    parameter int DEPTH  = 224,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays get no reset; resetting them would force flops
    // instead of RAM and nothing downstream relies on initial contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/linebuffer_3x3_stream_cfg.sv
// -----------------------------------------------------------------------------
// linebuffer_3x3_stream_cfg
// Streaming 3x3 window generator. Buffers the two previous lines of a raster
// stream and emits a registered 3x3 window with valid / end-of-row strobes.
// Line length and stride are captured on each accepted start-of-frame pixel.
// Ports:
//  clk          in   1          system clock, rising edge
//  rst_n        in   1          asynchronous reset, active low
//  cfg_len      in   LEN_W      line length (clamped to 3..MAX_LEN), taken at SOF
//  cfg_stride2  in   1          0 = stride 1, 1 = stride 2, taken at SOF
//  in_valid     in   1          in_data / in_sof valid
//  in_sof       in   1          first pixel of a frame (qualified by in_valid)
//  in_data      in   DATA_W     pixel, raster order
//  win_valid    out  1          win_data holds a complete in-frame window
//  win_eol      out  1          last window of the current row
//  win_data     out  9*DATA_W   window, tap 0 = top-left, tap 8 = newest pixel
// -----------------------------------------------------------------------------
module linebuffer_3x3_stream_cfg
    import cnn_pkg::*;
#(
    parameter int DATA_W  = PIX_W,
    parameter int MAX_LEN = 224,
    parameter int LEN_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LEN_W-1:0]             cfg_len,
    input  logic                         cfg_stride2,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         win_valid,
    output logic                         win_eol,
    output logic [WIN_TAPS*DATA_W-1:0]   win_data
);

    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(3);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ROW_SAT = '1;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len < LEN_MIN) return LEN_MIN;
        if (len > LEN_MAX) return LEN_MAX;
        return len;
    endfunction

    lb_state_t state_q, state_d;
    logic      in_run;

    logic [LEN_W-1:0] col_q, row_q, len_q;
    stride_t          stride_q;

    // Per-pixel view: a SOF pixel sees (0,0) and the freshly sampled config.
    logic             accept;
    logic [LEN_W-1:0] col_a, row_a, len_a, last_col, eol_col;
    stride_t          stride_a;
    logic             at_row_end, win_hit;

    logic [DATA_W-1:0] line0_rd, line1_rd;
    logic [WIN_TAPS-1:0][DATA_W-1:0] win_q;

    // ---------------- FSM ----------------
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LB_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (in_valid && in_sof) state_d = LB_RUN;
    end

    always_comb begin
        in_run = (state_q == LB_RUN);
    end

    // ---------------- per-pixel decode ----------------
    assign accept   = in_valid && (in_sof || in_run);
    assign col_a    = in_sof ? '0 : col_q;
    assign row_a    = in_sof ? '0 : row_q;
    assign len_a    = in_sof ? clamp_len(cfg_len) : len_q;
    assign stride_a = in_sof ? stride_t'(cfg_stride2) : stride_q;

    assign last_col   = len_a - LEN_W'(1);
    assign at_row_end = (col_a == last_col);
    // With stride 2 only even columns produce windows, so the row's last
    // window sits on the highest even column.
    assign eol_col    = (stride_a == STRIDE_2) ? {last_col[LEN_W-1:1], 1'b0} : last_col;

    // c >= 2 guarantees the three window columns all belong to the current row;
    // r >= 2 masks line-RAM contents left over from a previous frame.
    assign win_hit = (row_a >= LEN_W'(2)) && (col_a >= LEN_W'(2)) &&
                     ((stride_a == STRIDE_1) || (!row_a[0] && !col_a[0]));

    // ---------------- counters / config ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            len_q    <= LEN_MIN;
            stride_q <= STRIDE_1;
        end else if (accept) begin
            if (at_row_end) begin
                col_q <= '0;
                row_q <= (row_a == ROW_SAT) ? row_a : row_a + LEN_W'(1);
            end else begin
                col_q <= col_a + LEN_W'(1);
                row_q <= row_a;
            end
            if (in_sof) begin
                len_q    <= len_a;
                stride_q <= stride_a;
            end
        end
    end

    // ---------------- line memories ----------------
    // line0 holds the previous row, line1 the row before it; line1 takes the
    // word line0 is about to lose.
    com_line_ram #(.DEPTH(MAX_LEN), .WIDTH(DATA_W), .ADDR_W(LEN_W)) u_line0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_a),
        .wdata (in_data),
        .rdata (line0_rd)
    );

    com_line_ram #(.DEPTH(MAX_LEN), .WIDTH(DATA_W), .ADDR_W(LEN_W)) u_line1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_a),
        .wdata (line0_rd),
        .rdata (line1_rd)
    );

    // ---------------- window and strobes ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (accept) begin
            win_q[TAP_TL] <= win_q[TAP_TC];
            win_q[TAP_TC] <= win_q[TAP_TR];
            win_q[TAP_TR] <= line1_rd;
            win_q[TAP_ML] <= win_q[TAP_MC];
            win_q[TAP_MC] <= win_q[TAP_MR];
            win_q[TAP_MR] <= line0_rd;
            win_q[TAP_BL] <= win_q[TAP_BC];
            win_q[TAP_BC] <= win_q[TAP_BR];
            win_q[TAP_BR] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_eol   <= 1'b0;
        end else begin
            win_valid <= accept && win_hit;
            win_eol   <= accept && win_hit && (col_a == eol_col);
        end
    end

    assign win_data = win_q;

endmodule

// File: tb/tb_linebuffer_3x3_stream_cfg.sv
// -----------------------------------------------------------------------------
// tb_linebuffer_3x3_stream_cfg
// Directed bench for the 3x3 streaming window generator. Pixels carry their
// in-frame raster index (idx = row*len + col, truncated to 8 bits), so any
// window is predictable from its (row, col) position.
// -----------------------------------------------------------------------------
module tb_linebuffer_3x3_stream_cfg;

    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 224;
    localparam int LEN_W   = 8;
    localparam int WW      = 9 * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [LEN_W-1:0]  cfg_len;
    logic              cfg_stride2;
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic              win_valid;
    logic              win_eol;
    logic [WW-1:0]     win_data;

    always #5 clk = ~clk;

    linebuffer_3x3_stream_cfg #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_len     (cfg_len),
        .cfg_stride2 (cfg_stride2),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .win_valid   (win_valid),
        .win_eol     (win_eol),
        .win_data    (win_data)
    );

    typedef struct {
        int          frame;
        int          idx;
        logic        v;
        logic        e;
        logic [WW-1:0] d;
    } vec_t;

    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic          log_v [1024];
    logic          log_e [1024];
    logic [WW-1:0] log_d [1024];
    logic [WW-1:0] cur_wins[$];
    logic [WW-1:0] ref_wins[$];

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Window literal written MSB tap first, as in hand-drawn windows.
    function automatic logic [WW-1:0] win9(input int t8, t7, t6, t5, t4, t3, t2, t1, t0);
        return {8'(t8), 8'(t7), 8'(t6), 8'(t5), 8'(t4), 8'(t3), 8'(t2), 8'(t1), 8'(t0)};
    endfunction

    function automatic vec_t mk(input int frame, input int idx, input logic v, input logic e,
                                input logic [WW-1:0] d);
        vec_t t;
        t.frame = frame; t.idx = idx; t.v = v; t.e = e; t.d = d;
        return t;
    endfunction

    // Streams npix pixels of one frame (SOF on the first), optionally with
    // random idle gaps, checking every output cycle against positional
    // expectations, then checks the window / end-of-row totals.
    task automatic run_frame(input int cfg, input int len, input bit s2, input int npix,
                             input int gap_pct, input int exp_wins, input int exp_eols,
                             input string tag);
        int idx = 0;
        int wins = 0;
        int eols = 0;
        int r, c, lastc;
        logic ev, ee;
        logic [WW-1:0] ed;
        cur_wins.delete();
        while (idx < npix) begin
            @(negedge clk);
            if (idx > 0 && int'($urandom_range(99)) < gap_pct) begin
                in_valid    = 1'b0;
                in_sof      = 1'($urandom);
                in_data     = 8'($urandom);
                cfg_len     = 8'($urandom);
                cfg_stride2 = 1'($urandom);
                @(posedge clk); #1;
                check({tag, "_gap_valid"}, win_valid, 1'b0);
            end else begin
                in_valid    = 1'b1;
                in_sof      = (idx == 0);
                in_data     = 8'(idx);
                cfg_len     = (idx == 0) ? 8'(cfg) : 8'($urandom);
                cfg_stride2 = (idx == 0) ? s2 : 1'($urandom);
                @(posedge clk); #1;
                r     = idx / len;
                c     = idx % len;
                ev    = (r >= 2) && (c >= 2) && (!s2 || ((r % 2 == 0) && (c % 2 == 0)));
                lastc = s2 ? ((len - 1) / 2) * 2 : len - 1;
                ee    = ev && (c == lastc);
                check($sformatf("%s_valid_r%0d_c%0d", tag, r, c), win_valid, ev);
                check($sformatf("%s_eol_r%0d_c%0d", tag, r, c), win_eol, ee);
                if (ev) begin
                    ed = '0;
                    for (int k = 0; k < 3; k++)
                        for (int j = 0; j < 3; j++)
                            ed[(k*3+j)*8 +: 8] = 8'((r - 2 + k) * len + (c - 2 + j));
                    check($sformatf("%s_data_r%0d_c%0d", tag, r, c), win_data, ed);
                end
                if (idx < 1024) begin
                    log_v[idx] = win_valid;
                    log_e[idx] = win_eol;
                    log_d[idx] = win_data;
                end
                if (win_valid === 1'b1) begin
                    wins++;
                    cur_wins.push_back(win_data);
                end
                if (win_eol === 1'b1) eols++;
                idx++;
            end
        end
        check({tag, "_win_count"}, WW'(wins), WW'(exp_wins));
        check({tag, "_eol_count"}, WW'(eols), WW'(exp_eols));
    endtask

    task automatic check_table(input int frame);
        foreach (vecs[i]) begin
            if (vecs[i].frame == frame) begin
                check($sformatf("vec%0d_f%0d_i%0d_valid", i, frame, vecs[i].idx),
                      log_v[vecs[i].idx], vecs[i].v);
                check($sformatf("vec%0d_f%0d_i%0d_eol", i, frame, vecs[i].idx),
                      log_e[vecs[i].idx], vecs[i].e);
                if (vecs[i].v)
                    check($sformatf("vec%0d_f%0d_i%0d_data", i, frame, vecs[i].idx),
                          log_d[vecs[i].idx], vecs[i].d);
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        int cnt;

        // Hand-computed checkpoints: frame 2 = len 8 stride 1, frame 3 = len 8
        // stride 2, frame 5 = restarted frame with len 4.
        vecs.push_back(mk(2, 17, 1'b0, 1'b0, '0));
        vecs.push_back(mk(2, 18, 1'b1, 1'b0, win9(18, 17, 16, 10, 9, 8, 2, 1, 0)));
        vecs.push_back(mk(2, 23, 1'b1, 1'b1, win9(23, 22, 21, 15, 14, 13, 7, 6, 5)));
        vecs.push_back(mk(2, 24, 1'b0, 1'b0, '0));
        vecs.push_back(mk(2, 26, 1'b1, 1'b0, win9(26, 25, 24, 18, 17, 16, 10, 9, 8)));
        vecs.push_back(mk(2, 63, 1'b1, 1'b1, win9(63, 62, 61, 55, 54, 53, 47, 46, 45)));
        vecs.push_back(mk(3, 18, 1'b1, 1'b0, win9(18, 17, 16, 10, 9, 8, 2, 1, 0)));
        vecs.push_back(mk(3, 19, 1'b0, 1'b0, '0));
        vecs.push_back(mk(3, 22, 1'b1, 1'b1, win9(22, 21, 20, 14, 13, 12, 6, 5, 4)));
        vecs.push_back(mk(3, 26, 1'b0, 1'b0, '0));
        vecs.push_back(mk(3, 36, 1'b1, 1'b0, win9(36, 35, 34, 28, 27, 26, 20, 19, 18)));
        vecs.push_back(mk(3, 54, 1'b1, 1'b1, win9(54, 53, 52, 46, 45, 44, 38, 37, 36)));
        vecs.push_back(mk(5, 9,  1'b0, 1'b0, '0));
        vecs.push_back(mk(5, 10, 1'b1, 1'b0, win9(10, 9, 8, 6, 5, 4, 2, 1, 0)));
        vecs.push_back(mk(5, 11, 1'b1, 1'b1, win9(11, 10, 9, 7, 6, 5, 3, 2, 1)));

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        in_data     = '0;
        cfg_len     = '0;
        cfg_stride2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", win_valid, 1'b0);
        check("reset_eol", win_eol, 1'b0);
        check("reset_data", win_data, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: no SOF -> everything dropped in IDLE.
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_data  = 8'(i + 1);
            @(posedge clk); #1;
            if (win_valid === 1'b1) cnt++;
        end
        check("t1_idle_win_count", WW'(cnt), '0);
        check("t1_idle_data", win_data, '0);

        // Test 2: len 8, stride 1.
        run_frame(8, 8, 1'b0, 64, 0, 36, 6, "t2");
        ref_wins = cur_wins;
        check_table(2);

        // Test 3: len 8, stride 2.
        run_frame(8, 8, 1'b1, 64, 0, 9, 3, "t3");
        check_table(3);

        // Test 4: test 2 stream with ~50% gaps -> identical window sequence.
        run_frame(8, 8, 1'b0, 64, 50, 36, 6, "t4");
        check("t4_seq_len", WW'(cur_wins.size()), WW'(ref_wins.size()));
        for (int i = 0; i < cur_wins.size() && i < ref_wins.size(); i++)
            check($sformatf("t4_seq_win%0d", i), cur_wins[i], ref_wins[i]);

        // Test 5: SOF mid-frame after 30 pixels, new length 4.
        run_frame(8, 8, 1'b0, 30, 0, 10, 1, "t5a");
        run_frame(4, 4, 1'b0, 16, 0, 4, 2, "t5b");
        check_table(5);

        // Test 6: length clamping.
        run_frame(1, 3, 1'b0, 12, 0, 2, 2, "t6_len1");
        run_frame(255, 224, 1'b0, 672, 0, 222, 1, "t6_len255");

        // Reset pulsed mid-row while a window is valid.
        run_frame(8, 8, 1'b0, 20, 0, 2, 0, "t7");
        check("t7_pre_rst_valid", win_valid, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("t7_async_valid", win_valid, 1'b0);
        check("t7_async_eol", win_eol, 1'b0);
        check("t7_async_data", win_data, '0);
        go_idle();
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_data  = 8'(i + 7);
            @(posedge clk); #1;
            if (win_valid === 1'b1) cnt++;
        end
        check("t7_idle_win_count", WW'(cnt), '0);
        check("t7_idle_data", win_data, '0);
        run_frame(8, 8, 1'b0, 24, 0, 6, 1, "t8");
        go_idle();
        @(posedge clk); #1;
        check("t8_idle_drop_valid", win_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
